// File: rtl/colisor_multi.sv
// colisor_multi: checks one shot against every ship record of a chosen player
//   memory, clears the first matching slot and decrements that ship's piece count.
// Ports: clk/reset (sync, active-high); start,x,y,alvo request a shot; rd_* / rd_data
//   form a one-cycle-latency read port; wr_* is a single-cycle write port;
//   busy/done and the result flags hit, sunk, fleet_destroyed, hit_addr report the outcome.
module colisor_multi #(
  parameter int COORD_W   = 4,
  parameter int SLOTS     = 5,
  parameter int N_RECORDS = 12,
  parameter int N_PLAYERS = 2,
  parameter int REC_W     = 64,
  localparam int PL_W     = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1,
  localparam int AD_W     = $clog2(N_RECORDS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [PL_W-1:0]  alvo,
  output logic             rd_en,
  output logic [AD_W-1:0]  rd_addr,
  output logic [PL_W-1:0]  rd_sel,
  input  logic [REC_W-1:0] rd_data,
  output logic             wr_en,
  output logic [AD_W-1:0]  wr_addr,
  output logic [PL_W-1:0]  wr_sel,
  output logic [REC_W-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic             sunk,
  output logic             fleet_destroyed,
  output logic [AD_W-1:0]  hit_addr
);

  localparam int SLOT_W  = 2 * COORD_W;
  localparam int CNT_LSB = 3 + SLOTS * SLOT_W;
  localparam int TOT_W   = 3 + AD_W;
  localparam logic [AD_W-1:0] LAST = AD_W'(N_RECORDS);

  if (REC_W < 6 + SLOTS * SLOT_W) begin : g_rec_w_check
    $error("colisor_multi: REC_W too small for SLOTS/COORD_W");
  end

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [AD_W-1:0]    c_q, c_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [PL_W-1:0]    alvo_q, alvo_d;
  // Accumulators built while scanning
  logic               acc_hit_q, acc_hit_d;
  logic               acc_sunk_q, acc_sunk_d;
  logic [AD_W-1:0]    acc_addr_q, acc_addr_d;
  logic [REC_W-1:0]   wdat_q, wdat_d;
  logic [TOT_W-1:0]   tot_q, tot_d;
  // Reported results, only updated on entry to DONE
  logic               res_hit_q, res_hit_d;
  logic               res_sunk_q, res_sunk_d;
  logic               res_fd_q, res_fd_d;
  logic [AD_W-1:0]    res_addr_q, res_addr_d;

  // Evaluation of the record currently on rd_data
  logic [SLOT_W-1:0]  shot;
  logic [2:0]         rec_cnt, new_cnt;
  logic               match_any;
  int                 match_slot;
  logic [REC_W-1:0]   mod_rec;
  logic               take;

  always_comb begin
    shot       = {y_q, x_q};
    rec_cnt    = rd_data[CNT_LSB +: 3];
    new_cnt    = (rec_cnt == 3'd0) ? 3'd0 : rec_cnt - 3'd1;
    match_any  = 1'b0;
    match_slot = 0;
    // Lowest matching slot wins; an all-zero shot never matches an empty slot.
    for (int k = 0; k < SLOTS; k++) begin
      if (!match_any && shot != '0 && rd_data[3 + SLOT_W*k +: SLOT_W] == shot) begin
        match_any  = 1'b1;
        match_slot = k;
      end
    end
    mod_rec = rd_data;
    for (int k = 0; k < SLOTS; k++) begin
      if (k == match_slot) begin
        mod_rec[3 + SLOT_W*k +: SLOT_W] = '0;
      end
    end
    mod_rec[CNT_LSB +: 3] = new_cnt;
  end

  always_comb begin
    state_d    = state_q;
    c_d        = c_q;
    x_d        = x_q;
    y_d        = y_q;
    alvo_d     = alvo_q;
    acc_hit_d  = acc_hit_q;
    acc_sunk_d = acc_sunk_q;
    acc_addr_d = acc_addr_q;
    wdat_d     = wdat_q;
    tot_d      = tot_q;
    res_hit_d  = res_hit_q;
    res_sunk_d = res_sunk_q;
    res_fd_d   = res_fd_q;
    res_addr_d = res_addr_q;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    take       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d        = x;
          y_d        = y;
          alvo_d     = alvo;
          c_d        = '0;
          acc_hit_d  = 1'b0;
          acc_sunk_d = 1'b0;
          acc_addr_d = '0;
          wdat_d     = '0;
          tot_d      = '0;
          res_hit_d  = 1'b0;
          res_sunk_d = 1'b0;
          res_fd_d   = 1'b0;
          res_addr_d = '0;
          state_d    = S_SCAN;
        end
      end
      S_SCAN: begin
        rd_en = (c_q != LAST);
        // rd_data holds record c-1 in cycle c
        if (c_q != '0) begin
          take = match_any && !acc_hit_q;
          if (take) begin
            acc_hit_d  = 1'b1;
            acc_addr_d = c_q - 1'b1;
            wdat_d     = mod_rec;
            acc_sunk_d = (new_cnt == 3'd0);
          end
          tot_d = tot_q + TOT_W'(take ? new_cnt : rec_cnt);
        end
        if (c_q == LAST) begin
          if (acc_hit_d) begin
            state_d = S_WRITE;
          end else begin
            res_fd_d = (tot_d == '0);
            state_d  = S_DONE;
          end
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      S_WRITE: begin
        wr_en      = 1'b1;
        res_hit_d  = acc_hit_q;
        res_sunk_d = acc_sunk_q;
        res_addr_d = acc_addr_q;
        res_fd_d   = (tot_q == '0);
        state_d    = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      c_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      alvo_q     <= '0;
      acc_hit_q  <= 1'b0;
      acc_sunk_q <= 1'b0;
      acc_addr_q <= '0;
      wdat_q     <= '0;
      tot_q      <= '0;
      res_hit_q  <= 1'b0;
      res_sunk_q <= 1'b0;
      res_fd_q   <= 1'b0;
      res_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      x_q        <= x_d;
      y_q        <= y_d;
      alvo_q     <= alvo_d;
      acc_hit_q  <= acc_hit_d;
      acc_sunk_q <= acc_sunk_d;
      acc_addr_q <= acc_addr_d;
      wdat_q     <= wdat_d;
      tot_q      <= tot_d;
      res_hit_q  <= res_hit_d;
      res_sunk_q <= res_sunk_d;
      res_fd_q   <= res_fd_d;
      res_addr_q <= res_addr_d;
    end
  end

  assign rd_addr         = rd_en ? c_q : '0;
  assign rd_sel          = alvo_q;
  assign wr_addr         = acc_addr_q;
  assign wr_sel          = alvo_q;
  assign wr_data         = wdat_q;
  assign busy            = (state_q == S_SCAN) || (state_q == S_WRITE);
  assign done            = (state_q == S_DONE);
  assign hit             = res_hit_q;
  assign sunk            = res_sunk_q;
  assign fleet_destroyed = res_fd_q;
  assign hit_addr        = res_addr_q;

endmodule
